present_dec_iter: RTL and testbench

//  Iterative PRESENT-80 decryption core; the inverse of the encryption round datapath.
//  Per cycle, one inverse round: inverse permutation, inverse 4-bit S-box layer
//  (16 nibbles), then round-key addition.

---
 rtl/present_dec_iter.sv | 144 ++++++++++++++
 tb/tb_present_dec_iter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/present_dec_iter.sv
// Iterative PRESENT-80 decryption: key schedule run forward, then one inverse round per cycle.
// Latency: ack rises 1+ROUNDS+1+ROUNDS edges after req is accepted; ack holds until req drops.
module present_dec_iter #(
   parameter int ROUNDS = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        ack,
   input  logic [63:0] c,
   input  logic [79:0] k,
   output logic [63:0] m
);
   localparam int CW = $clog2(ROUNDS + 1);

   typedef enum logic [2:0] {IDLE, KEYF, ADDK, RND, DONE} state_t;

   state_t          state, state_nx;
   logic [63:0]     s, s_nx, m_nx, s_rnd;
   logic [79:0]     key, key_nx, kp;
   logic [CW-1:0]   i, i_nx;
   logic [4:0]      rc;
   logic            ack_nx;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
      endcase
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      case (x)
         4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
         4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
         4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
         4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
      endcase
   endfunction

   function automatic logic [79:0] upd(input logic [79:0] kin, input logic [4:0] r);
      logic [79:0] t;
      t = {kin[18:0], kin[79:19]};
      t[79:76] = sbox(t[79:76]);
      t[19:15] = t[19:15] ^ r;
      return t;
   endfunction

   function automatic logic [79:0] inv_upd(input logic [79:0] kin, input logic [4:0] r);
      logic [79:0] t;
      t = kin;
      t[19:15] = t[19:15] ^ r;
      t[79:76] = inv_sbox(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

   // Output bit j gathers input bit 16*j mod 63; bit 63 is fixed.
   function automatic logic [63:0] inv_p(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int j = 0; j < 63; j++) y[j] = x[(16 * j) % 63];
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
      return y;
   endfunction

   assign rc    = 5'(i);
   assign kp    = inv_upd(key, rc);
   assign s_rnd = inv_s_layer(inv_p(s)) ^ kp[79:16];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s     <= '0;
         key   <= '0;
         i     <= '0;
         m     <= '0;
         ack   <= 1'b0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         key   <= key_nx;
         i     <= i_nx;
         m     <= m_nx;
         ack   <= ack_nx;
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      key_nx   = key;
      i_nx     = i;
      m_nx     = m;
      ack_nx   = ack;
      case (state)
         IDLE: begin
            if (req) begin
               s_nx     = c;
               key_nx   = k;
               i_nx     = CW'(1);
               state_nx = KEYF;
            end
         end
         KEYF: begin
            key_nx = upd(key, rc);
            i_nx   = i + CW'(1);
            if (i == CW'(ROUNDS)) begin
               i_nx     = CW'(ROUNDS);
               state_nx = ADDK;
            end
         end
         ADDK: begin
            s_nx     = s ^ key[79:16];
            state_nx = RND;
         end
         RND: begin
            s_nx   = s_rnd;
            key_nx = kp;
            i_nx   = i - CW'(1);
            if (i == CW'(1)) begin
               m_nx     = s_rnd;
               ack_nx   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (!req) begin
               ack_nx   = 1'b0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_present_dec_iter.sv
// Directed bench for present_dec_iter using the published PRESENT-80 test vectors.
module tb_present_dec_iter;
   logic        clk = 1'b0;
   logic        rst, req, ack;
   logic [63:0] c, m;
   logic [79:0] k;
   int          checks = 0;
   int          errors = 0;
   int          n;

   localparam logic [79:0] K0 = 80'h0;
   localparam logic [79:0] KF = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] Z  = 64'h0;
   localparam logic [63:0] F  = 64'hFFFF_FFFF_FFFF_FFFF;

   present_dec_iter #(.ROUNDS(31)) dut (
      .clk(clk), .rst(rst), .req(req), .ack(ack), .c(c), .k(k), .m(m)
   );

   always #5 clk = ~clk;

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkint(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges from acceptance until ack is seen; optionally drops req or scrambles c/k.
   task automatic wait_ack(input string tag, input int drop_at, input int chg_at, output int cnt);
      cnt = 0;
      while (cnt < 200) begin
         tick();
         cnt++;
         if (drop_at > 0 && cnt == drop_at) req = 1'b0;
         if (chg_at > 0 && cnt == chg_at) begin
            c = 64'hDEAD_BEEF_0123_4567;
            k = 80'h1234_5678_9ABC_DEF0_5555;
         end
         if (ack === 1'b1) break;
      end
      checkint({tag, "_latency"}, cnt, 64);
   endtask

   task automatic run(input string tag, input logic [63:0] cv, input logic [79:0] kv,
                      input logic [63:0] exp);
      int cnt;
      c   = cv;
      k   = kv;
      req = 1'b1;
      wait_ack(tag, 0, 0, cnt);
      check64({tag, "_m"}, m, exp);
      req = 1'b0;
      tick();
      check1({tag, "_ack_low"}, ack, 1'b0);
      check64({tag, "_m_held"}, m, exp);
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0;
      c   = 64'h0123_4567_89AB_CDEF;
      k   = KF;
      tick();
      tick();
      check1("reset_ack", ack, 1'b0);
      check64("reset_m", m, Z);
      rst = 1'b0;
      tick();
      check1("idle_ack", ack, 1'b0);

      // Published vectors
      run("v_k0_p0", 64'h5579_C138_7B22_8445, K0, Z);
      run("v_kf_p0", 64'hE72C_46C0_F594_5049, KF, Z);
      run("v_k0_pf", 64'hA112_FFC7_2F68_417B, K0, F);
      run("v_kf_pf", 64'h3333_DCD3_2132_10D2, KF, F);

      // req held high through DONE
      c   = 64'h5579_C138_7B22_8445;
      k   = K0;
      req = 1'b1;
      wait_ack("hold", 0, 0, n);
      check64("hold_m", m, Z);
      for (int t = 0; t < 3; t++) begin
         tick();
         check1("hold_ack_high", ack, 1'b1);
      end
      check64("hold_m_stable", m, Z);
      req = 1'b0;
      tick();
      check1("hold_release_ack", ack, 1'b0);
      tick();
      tick();
      check1("hold_no_restart", ack, 1'b0);
      check64("hold_m_after", m, Z);

      // req dropped early: single ack pulse
      c   = 64'h3333_DCD3_2132_10D2;
      k   = KF;
      req = 1'b1;
      wait_ack("drop", 5, 0, n);
      check64("drop_m", m, F);
      tick();
      check1("drop_pulse_end", ack, 1'b0);
      check64("drop_m_held", m, F);
      tick();
      check1("drop_stay_idle", ack, 1'b0);

      // Reset in the middle of the inverse rounds
      c   = 64'h5579_C138_7B22_8445;
      k   = K0;
      req = 1'b1;
      for (int t = 0; t < 40; t++) tick();
      check1("midrst_no_ack_yet", ack, 1'b0);
      rst = 1'b1;
      req = 1'b0;
      tick();
      check1("midrst_ack", ack, 1'b0);
      check64("midrst_m", m, Z);
      rst = 1'b0;
      tick();
      run("after_rst", 64'hA112_FFC7_2F68_417B, K0, F);

      // Inputs scrambled mid-operation are ignored
      c   = 64'hE72C_46C0_F594_5049;
      k   = KF;
      req = 1'b1;
      wait_ack("chg", 0, 10, n);
      check64("chg_m", m, Z);
      req = 1'b0;
      tick();
      check1("chg_ack_low", ack, 1'b0);

      // Back-to-back with req toggled between
      run("b2b_a", 64'h3333_DCD3_2132_10D2, KF, F);
      run("b2b_b", 64'h5579_C138_7B22_8445, K0, Z);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
